alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequential front-end that accepts ALU work requests over a valid/ready handshake and decodes a compact function code into ALU control (operacion, invert, carry-in). It drives the N-bit ALU with registered operands, waits a programmable settle time, and captures result, carry, zero and overflow. Results are returned on a valid/ready response channel. It sits between the instruction decode/multi-cycle control and the ALUNBits datapath.

Parameters:
N, 4, operand/result width; matches the ALU width.
EXEC_CYCLES, 1, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; high only in IDLE
req_func_i  in  4  function code, see Behaviour
req_a_i  in  N  operand A
req_b_i  in  N  operand B / shift amount
alu_a_o  out  N  registered operand A to ALU
alu_b_o  out  N  registered operand B to ALU
alu_op_o  out  4  ALU operacion code
alu_invert_o  out  1  ALU B-invert
alu_cin_o  out  1  ALU carry-in
alu_res_i  in  N  ALU result
alu_cout_i  in  1  ALU carry-out
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response accepted
resp_data_o  out  N  captured result
resp_carry_o  out  1  captured carry-out
resp_zero_o  out  1  resp_data_o == 0
resp_ovf_o  out  1  signed overflow (ADD/SUB only, else 0)
resp_err_o  out  1  illegal function code

Behaviour:
- Reset (async, rst_ni low): state IDLE, counter 0, all outputs 0 except req_ready_o=1. Reset mid-operation discards the request; no response is produced.
- Function codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, A SRA; B-F illegal.
- ALU op encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLT 0100, SLTU 0101, SRL 0110, SLL 0111, SRA 1000, NOR 1001.
- Decode: SUB, SLT and SLTU use invert=1, cin=1. All other codes use invert=0, cin=0.
- FSM IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: req_ready_o=1. On req_valid_i, latch operands and decoded controls into alu_* registers, load counter = EXEC_CYCLES-1, go to EXEC.
  - IDLE with an illegal code: go directly to RESP with data=0, carry=0, ovf=0, zero=1, err=1. alu_* outputs are unchanged.
  - EXEC: alu_* outputs are held stable. While counter != 0, decrement it. When counter == 0, capture alu_res_i, alu_cout_i, compute zero and ovf, go to RESP.
  - RESP: resp_valid_o=1 with all resp_* stable until resp_ready_i. On handshake, go to IDLE; resp_valid_o drops the next cycle.
- Latency: a handshake at cycle T gives resp_valid_o at T+EXEC_CYCLES+1. Minimum request-to-request spacing is EXEC_CYCLES+2 cycles. There is no overlap or buffering.
- Overflow: ADD sets ovf when a[N-1]==b[N-1] and res[N-1]!=a[N-1]. SUB uses ~b in place of b.
- resp_carry_o is valid for ADD/SUB. For other operations it is the raw ALU carry-out.
- resp_ready_i outside RESP is ignored. A held req_valid_i outside IDLE is not accepted.

Decomposition:
- Shared package alu_pkg holds:
  - the function-code localparams and ALU op-code localparams;
  - the FSM state encoding;
  - a decode function mapping func to {op, invert, cin, legal}.
- Optional sub-module alu_func_decoder (purely combinational decode).
- Testbench instantiates alu_issue_ctrl with ALUNBits.

Test Plan:
- N=4, EXEC_CYCLES=1, ADD a=0111 b=1001, resp_ready_i=1 -> resp_valid_o at T+2, data=0000, carry=1, zero=1, ovf=0, err=0.
- SUB a=0011 b=0101 -> alu_invert_o=1, alu_cin_o=1 during EXEC; data=1110, carry=0, ovf=0, zero=0.
- ADD a=0111 b=0001 -> data=1000, ovf=1. SUB a=1000 b=0001 -> data=0111, ovf=1.
- func=F with req_valid_i=1 -> resp at T+1, err=1, data=0, zero=1; alu_* outputs unchanged.
- EXEC_CYCLES=3, SLL a=0011 b=0001, resp_ready_i low for 5 cycles -> resp_valid_o at T+4; data held stable for 5 cycles; req_ready_o=0 throughout; IDLE after handshake.
- Pull rst_ni low during EXEC -> all outputs 0 immediately, req_ready_o=1; no response is ever issued; the next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue front-end.
//   - function-code constants (request side)
//   - ALU operation-code constants (ALUNBits side)
//   - FSM state encoding
//   - decode_func(): function code -> {op, invert, cin, legal}
package alu_pkg;

  // Request function codes
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_AND  = 4'h2;
  localparam logic [3:0] FN_OR   = 4'h3;
  localparam logic [3:0] FN_XOR  = 4'h4;
  localparam logic [3:0] FN_NOR  = 4'h5;
  localparam logic [3:0] FN_SLT  = 4'h6;
  localparam logic [3:0] FN_SLTU = 4'h7;
  localparam logic [3:0] FN_SLL  = 4'h8;
  localparam logic [3:0] FN_SRL  = 4'h9;
  localparam logic [3:0] FN_SRA  = 4'hA;

  // ALU operacion codes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       invert;
    logic       cin;
    logic       legal;
  } dec_t;

  // Subtraction-style operations (SUB, SLT, SLTU) run the adder as a + ~b + 1,
  // so they share the invert/carry-in setting.
  function automatic dec_t decode_func(input logic [3:0] func);
    dec_t d;
    d.op     = OP_AND;
    d.invert = 1'b0;
    d.cin    = 1'b0;
    d.legal  = 1'b1;
    case (func)
      FN_ADD:  d.op = OP_ADD;
      FN_SUB:  begin d.op = OP_ADD;  d.invert = 1'b1; d.cin = 1'b1; end
      FN_AND:  d.op = OP_AND;
      FN_OR:   d.op = OP_OR;
      FN_XOR:  d.op = OP_XOR;
      FN_NOR:  d.op = OP_NOR;
      FN_SLT:  begin d.op = OP_SLT;  d.invert = 1'b1; d.cin = 1'b1; end
      FN_SLTU: begin d.op = OP_SLTU; d.invert = 1'b1; d.cin = 1'b1; end
      FN_SLL:  d.op = OP_SLL;
      FN_SRL:  d.op = OP_SRL;
      FN_SRA:  d.op = OP_SRA;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decoder.sv
// alu_func_decoder: purely combinational function-code decoder.
// Ports:
//   func   in  4  request function code
//   op     out 4  ALU operacion code
//   invert out 1  ALU B-invert
//   cin    out 1  ALU carry-in
//   legal  out 1  function code is defined
module alu_func_decoder
  import alu_pkg::*;
(
  input  logic [3:0] func,
  output logic [3:0] op,
  output logic       invert,
  output logic       cin,
  output logic       legal
);

  dec_t dec;

  always_comb begin
    dec    = decode_func(func);
    op     = dec.op;
    invert = dec.invert;
    cin    = dec.cin;
    legal  = dec.legal;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts ALU work requests (valid/ready), drives the N-bit
// ALU with registered operands and controls, waits EXEC_CYCLES, captures the
// result and returns it on a valid/ready response channel.
// Parameters: N (datapath width), EXEC_CYCLES (1..15 hold cycles before capture).
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   req_valid_i/req_ready_o    request handshake (ready only in IDLE)
//   req_func_i, req_a_i/b_i    function code and operands
//   alu_a_o/b_o/op_o           registered ALU operands and operacion
//   alu_invert_o/alu_cin_o     registered ALU B-invert and carry-in
//   alu_res_i/alu_cout_i       ALU result and carry-out
//   resp_valid_o/resp_ready_i  response handshake
//   resp_data_o/carry/zero/ovf/err  captured response fields
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N           = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [3:0]   req_func_i,
  input  logic [N-1:0] req_a_i,
  input  logic [N-1:0] req_b_i,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [3:0]   alu_op_o,
  output logic         alu_invert_o,
  output logic         alu_cin_o,
  input  logic [N-1:0] alu_res_i,
  input  logic         alu_cout_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic [N-1:0] resp_data_o,
  output logic         resp_carry_o,
  output logic         resp_zero_o,
  output logic         resp_ovf_o,
  output logic         resp_err_o
);

  // Counter reload; EXEC_CYCLES is expected within 1..15.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t       state_reg, state_next;
  logic [3:0]   cnt_reg;
  logic [N-1:0] alu_a_reg, alu_b_reg;
  logic [3:0]   op_reg;
  logic         inv_reg, cin_reg, ovf_en_reg;
  logic [N-1:0] resp_data_reg;
  logic         resp_carry_reg, resp_zero_reg, resp_ovf_reg, resp_err_reg;

  logic [3:0]   dec_op;
  logic         dec_invert, dec_cin, dec_legal;
  logic         req_is_addsub;
  logic [N-1:0] b_eff;
  logic         ovf_calc;

  alu_func_decoder u_dec (
    .func   (req_func_i),
    .op     (dec_op),
    .invert (dec_invert),
    .cin    (dec_cin),
    .legal  (dec_legal)
  );

  assign req_is_addsub = (req_func_i == FN_ADD) || (req_func_i == FN_SUB);

  // Operand B as the adder actually sees it (inverted for SUB).
  for (genvar gi = 0; gi < N; gi++) begin : g_beff
    assign b_eff[gi] = alu_b_reg[gi] ^ inv_reg;
  end

  // Signed overflow: operand signs agree but the result sign differs.
  assign ovf_calc = ovf_en_reg
                  & (alu_a_reg[N-1] == b_eff[N-1])
                  & (alu_res_i[N-1] != alu_a_reg[N-1]);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_next = dec_legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg        <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      op_reg         <= '0;
      inv_reg        <= 1'b0;
      cin_reg        <= 1'b0;
      ovf_en_reg     <= 1'b0;
      resp_data_reg  <= '0;
      resp_carry_reg <= 1'b0;
      resp_zero_reg  <= 1'b0;
      resp_ovf_reg   <= 1'b0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (dec_legal) begin
              alu_a_reg  <= req_a_i;
              alu_b_reg  <= req_b_i;
              op_reg     <= dec_op;
              inv_reg    <= dec_invert;
              cin_reg    <= dec_cin;
              ovf_en_reg <= req_is_addsub;
              cnt_reg    <= CNT_LOAD;
            end else begin
              // Illegal code: answer immediately, leave the ALU drive untouched.
              resp_data_reg  <= '0;
              resp_carry_reg <= 1'b0;
              resp_zero_reg  <= 1'b1;
              resp_ovf_reg   <= 1'b0;
              resp_err_reg   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            resp_data_reg  <= alu_res_i;
            resp_carry_reg <= alu_cout_i;
            resp_zero_reg  <= (alu_res_i == '0);
            resp_ovf_reg   <= ovf_calc;
            resp_err_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_reg == ST_IDLE);
  assign resp_valid_o = (state_reg == ST_RESP);
  assign alu_a_o      = alu_a_reg;
  assign alu_b_o      = alu_b_reg;
  assign alu_op_o     = op_reg;
  assign alu_invert_o = inv_reg;
  assign alu_cin_o    = cin_reg;
  assign resp_data_o  = resp_data_reg;
  assign resp_carry_o = resp_carry_reg;
  assign resp_zero_o  = resp_zero_reg;
  assign resp_ovf_o   = resp_ovf_reg;
  assign resp_err_o   = resp_err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: two instances (EXEC_CYCLES=1 and 3), each
// driving a behavioural ALUNBits stand-in. Expected responses come from an
// arithmetic reference model of the function codes.
module tb_alu_issue_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req_valid   [2];
  logic         req_ready   [2];
  logic [3:0]   req_func    [2];
  logic [N-1:0] req_a       [2];
  logic [N-1:0] req_b       [2];
  logic [N-1:0] alu_a       [2];
  logic [N-1:0] alu_b       [2];
  logic [3:0]   alu_op      [2];
  logic         alu_invert  [2];
  logic         alu_cin     [2];
  logic [N-1:0] alu_res     [2];
  logic         alu_cout    [2];
  logic         resp_valid  [2];
  logic         resp_ready  [2];
  logic [N-1:0] resp_data   [2];
  logic         resp_carry  [2];
  logic         resp_zero   [2];
  logic         resp_ovf    [2];
  logic         resp_err    [2];

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int EC = (gi == 0) ? 1 : 3;
    logic [N:0]   sum;
    logic [N-1:0] bx, res;

    // ALUNBits stand-in: adder with B-invert/carry-in plus logic and shifts.
    always_comb begin
      bx  = alu_invert[gi] ? ~alu_b[gi] : alu_b[gi];
      sum = {1'b0, alu_a[gi]} + {1'b0, bx} + {{N{1'b0}}, alu_cin[gi]};
      res = '0;
      case (alu_op[gi])
        4'b0000: res = alu_a[gi] & alu_b[gi];
        4'b0001: res = alu_a[gi] | alu_b[gi];
        4'b0010: res = sum[N-1:0];
        4'b0011: res = alu_a[gi] ^ alu_b[gi];
        4'b0100: res = {{(N-1){1'b0}}, $signed(alu_a[gi]) < $signed(alu_b[gi])};
        4'b0101: res = {{(N-1){1'b0}}, alu_a[gi] < alu_b[gi]};
        4'b0110: res = alu_a[gi] >> alu_b[gi];
        4'b0111: res = alu_a[gi] << alu_b[gi];
        4'b1000: res = $signed(alu_a[gi]) >>> alu_b[gi];
        4'b1001: res = ~(alu_a[gi] | alu_b[gi]);
        default: res = '0;
      endcase
    end
    assign alu_res[gi]  = res;
    assign alu_cout[gi] = sum[N];

    alu_issue_ctrl #(.N(N), .EXEC_CYCLES(EC)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid[gi]),
      .req_ready_o  (req_ready[gi]),
      .req_func_i   (req_func[gi]),
      .req_a_i      (req_a[gi]),
      .req_b_i      (req_b[gi]),
      .alu_a_o      (alu_a[gi]),
      .alu_b_o      (alu_b[gi]),
      .alu_op_o     (alu_op[gi]),
      .alu_invert_o (alu_invert[gi]),
      .alu_cin_o    (alu_cin[gi]),
      .alu_res_i    (alu_res[gi]),
      .alu_cout_i   (alu_cout[gi]),
      .resp_valid_o (resp_valid[gi]),
      .resp_ready_i (resp_ready[gi]),
      .resp_data_o  (resp_data[gi]),
      .resp_carry_o (resp_carry[gi]),
      .resp_zero_o  (resp_zero[gi]),
      .resp_ovf_o   (resp_ovf[gi]),
      .resp_err_o   (resp_err[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {err, ovf, zero, carry, data[3:0]}.
  function automatic logic [7:0] ref_model(input int f, input int a, input int b);
    int sa, sb, r, c, v, e;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c  = ((a + b) >= 16) ? 1 : 0;   // raw adder carry with no inversion
    v  = 0;
    e  = 0;
    r  = 0;
    case (f)
      0:  begin r = a + b; v = ((sa + sb) > 7 || (sa + sb) < -8) ? 1 : 0; end
      1:  begin r = a - b + 16; c = (a >= b) ? 1 : 0;
                v = ((sa - sb) > 7 || (sa - sb) < -8) ? 1 : 0; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a | b);
      6:  begin r = (sa < sb) ? 1 : 0; c = (a >= b) ? 1 : 0; end
      7:  begin r = (a < b) ? 1 : 0;   c = (a >= b) ? 1 : 0; end
      8:  r = a << b;
      9:  r = a >> b;
      10: r = sa >>> b;
      default: begin e = 1; c = 0; end
    endcase
    r = r & 15;
    return {e[0], v[0], (r == 0), c[0], r[3:0]};
  endfunction

  function automatic logic [3:0] exp_op(input int f);
    case (f)
      0, 1: return 4'b0010;
      2:    return 4'b0000;
      3:    return 4'b0001;
      4:    return 4'b0011;
      5:    return 4'b1001;
      6:    return 4'b0100;
      7:    return 4'b0101;
      8:    return 4'b0111;
      9:    return 4'b0110;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic run_txn(input int d, input int f, input int a, input int b, input int stall);
    int         ec, exp_lat, lat;
    bit         legal, got, inv;
    logic [7:0] e;
    logic [3:0] pre_a, pre_b, pre_op;
    ec      = (d == 0) ? 1 : 3;
    legal   = (f <= 10);
    inv     = (f == 1 || f == 6 || f == 7);
    exp_lat = legal ? ec + 1 : 1;
    e       = ref_model(f, a, b);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    pre_a  = alu_a[d];
    pre_b  = alu_b[d];
    pre_op = alu_op[d];
    req_valid[d]  = 1'b1;
    req_func[d]   = 4'(f);
    req_a[d]      = 4'(a);
    req_b[d]      = 4'(b);
    resp_ready[d] = (stall == 0);
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      // Scramble operands: the ALU drive must stay on the latched copy.
      req_a[d] = 4'($urandom_range(0, 15));
      req_b[d] = 4'($urandom_range(0, 15));
      if (resp_valid[d]) begin
        got = 1;
      end else begin
        chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
        chk("alu_a_hold",  32'(alu_a[d]),      32'(a));
        chk("alu_b_hold",  32'(alu_b[d]),      32'(b));
        chk("alu_op",      32'(alu_op[d]),     32'(exp_op(f)));
        chk("alu_invert",  32'(alu_invert[d]), 32'(inv));
        chk("alu_cin",     32'(alu_cin[d]),    32'(inv));
      end
    end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    if (got) begin
      for (int s = 0; s < ((stall > 0) ? stall : 1); s++) begin
        if (s > 0) @(negedge clk);
        chk("resp_valid_held", 32'(resp_valid[d]), 32'd1);
        chk("req_ready_resp",  32'(req_ready[d]),  32'd0);
        chk("resp_fields", {27'd0, resp_err[d], resp_ovf[d], resp_zero[d], resp_carry[d], resp_data[d]},
            {27'd0, e[7:4] == 4'd0 ? 1'b0 : e[7], e[6], e[5], e[4], e[3:0]});
        if (!legal) begin
          chk("alu_unchanged", {20'd0, alu_a[d], alu_b[d], alu_op[d]}, {20'd0, pre_a, pre_b, pre_op});
        end
      end
      resp_ready[d] = 1'b1;
      @(negedge clk);
      chk("resp_valid_drop", 32'(resp_valid[d]), 32'd0);
      chk("req_ready_back",  32'(req_ready[d]),  32'd1);
    end
    $display("txn dut=%0d func=%0h a=%0h b=%0h stall=%0d lat=%0d data=%0h c=%0b z=%0b v=%0b err=%0b",
             d, f, a, b, stall, lat, resp_data[d], resp_carry[d], resp_zero[d], resp_ovf[d], resp_err[d]);
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    bit saw_resp;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_func[i]   = 4'h0;
      req_a[i]      = '0;
      req_b[i]      = '0;
      resp_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 32'(req_ready[i]), 32'd1);
      chk("reset_outs", {16'd0, alu_a[i], alu_b[i], alu_op[i], alu_invert[i], alu_cin[i],
                         resp_valid[i], resp_carry[i], resp_zero[i], resp_ovf[i], resp_err[i], 1'b0},
          32'd0);
      chk("reset_data", 32'(resp_data[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_txn(0, 0,  7, 9, 0);
    run_txn(0, 1,  3, 5, 0);
    run_txn(0, 0,  7, 1, 1);
    run_txn(0, 1,  8, 1, 0);
    run_txn(0, 15, 0, 0, 0);
    run_txn(1, 8,  3, 1, 5);
    run_txn(1, 12, 5, 6, 2);

    // Reset during EXEC on the 3-cycle instance
    @(negedge clk);
    req_valid[1] = 1'b1; req_func[1] = 4'h0; req_a[1] = 4'h5; req_b[1] = 4'h6;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    chk("rst_exec_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_exec_outs", {16'd0, alu_a[1], alu_b[1], alu_op[1], alu_invert[1], alu_cin[1],
                          resp_valid[1], resp_carry[1], resp_zero[1], resp_ovf[1], resp_err[1], 1'b0},
        32'd0);
    chk("rst_exec_data", 32'(resp_data[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid[1]) saw_resp = 1;
    end
    chk("rst_no_resp", 32'(saw_resp), 32'd0);
    resp_ready[1] = 1'b0;
    $display("txn dut=1 reset during EXEC, no response observed=%0b", saw_resp);
    run_txn(1, 0, 5, 6, 0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      run_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
